// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request ports and unified memory bus of mem_port_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  flush_i;
  logic [DATA_WIDTH-1:0] if_rdata_o;
  logic                  if_ready_o;
  logic                  dm_req_i;
  logic                  dm_we_i;
  logic [ADDR_WIDTH-1:0] dm_addr_i;
  logic [DATA_WIDTH-1:0] dm_wdata_i;
  logic [DATA_WIDTH-1:0] dm_rdata_o;
  logic                  dm_ready_o;
  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  grant_o;
  logic                  stall_o;

  modport slave (
    input  if_req_i, if_addr_i, flush_i,
    output if_rdata_o, if_ready_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output dm_rdata_o, dm_ready_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output grant_o, stall_o
  );

  modport master (
    output if_req_i, if_addr_i, flush_i,
    input  if_rdata_o, if_ready_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  dm_rdata_o, dm_ready_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  grant_o, stall_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports,
// DM-first with a starvation guard, fixed wait states per access.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [1:0]            starve_q, starve_d;
  logic                  flush_seen_q, flush_seen_d;
  logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

  logic access, if_rdy, dm_rdy;
  logic grant_dm, grant_if;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    starve_d     = starve_q;
    flush_seen_d = flush_seen_q;
    rbuf_d       = rbuf_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    grant_dm     = 1'b0;
    grant_if     = 1'b0;
    access       = (state_q == ACCESS);
    // a flush seen at any point, even during RESP, kills the fetch
    if_rdy = (state_q == RESP) && !owner_q
           && !flush_seen_q && !bus.flush_i;
    dm_rdy = (state_q == RESP) && owner_q;

    if (!bus.if_req_i) starve_d = 2'd0;

    unique case (state_q)
      IDLE: begin
        if (bus.dm_req_i && starve_q < 2'd2) begin
          grant_dm = 1'b1;
        end else if (bus.if_req_i && !bus.flush_i) begin
          grant_if = 1'b1;
        end else if (bus.dm_req_i) begin
          grant_dm = 1'b1;
        end
        if (grant_dm || grant_if) begin
          owner_d      = grant_dm;
          addr_d       = grant_dm ? bus.dm_addr_i : bus.if_addr_i;
          we_d         = grant_dm & bus.dm_we_i;
          wdata_d      = grant_dm ? bus.dm_wdata_i : '0;
          cnt_d        = WS;
          flush_seen_d = 1'b0;
          state_d      = ACCESS;
        end
        if (grant_if) begin
          starve_d = 2'd0;
        end else if (grant_dm && bus.if_req_i && starve_q != 2'd3) begin
          starve_d = starve_q + 2'd1;
        end
      end
      ACCESS: begin
        flush_seen_d = flush_seen_q | bus.flush_i;
        if (cnt_q == 3'd0) begin
          if (!we_q) rbuf_d = bus.mem_rdata_i;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (if_rdy) if_rdata_d = rbuf_q;
        if (dm_rdy && !we_q) dm_rdata_d = rbuf_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      starve_q     <= '0;
      flush_seen_q <= 1'b0;
      rbuf_q       <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      flush_seen_q <= flush_seen_d;
      rbuf_q       <= rbuf_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  // read data is presented during the ready pulse, then held
  assign bus.mem_en_o    = access;
  assign bus.mem_we_o    = access && cnt_q == 3'd0 && we_q;
  assign bus.mem_addr_o  = access ? addr_q : '0;
  assign bus.mem_wdata_o = access ? wdata_q : '0;
  assign bus.if_ready_o  = if_rdy;
  assign bus.dm_ready_o  = dm_rdy;
  assign bus.if_rdata_o  = if_rdy ? rbuf_q : if_rdata_q;
  assign bus.dm_rdata_o  = (dm_rdy && !we_q) ? rbuf_q : dm_rdata_q;
  assign bus.grant_o     = owner_q;
  assign bus.stall_o     = (bus.if_req_i & ~if_rdy & ~bus.flush_i)
                         | (bus.dm_req_i & ~dm_rdy);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus
// scoreboard, with hand sequences for contention/flush/reset.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset, reset0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(1)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(0)
  ) dut0 (.clk(clk), .reset(reset0), .bus(bus0));

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {8'hA5, a[7:0], ~a[7:0], 8'h5A};
  endfunction

  logic [31:0] mem [0:255];
  assign bus.mem_rdata_i  = mem[bus.mem_addr_o[9:2]];
  assign bus0.mem_rdata_i = pat(bus0.mem_addr_o);

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(32'(i * 4));
    mem[16] = 32'h0050_0093;
    forever begin
      @(posedge clk);
      if (bus.mem_we_o) mem[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard: every ready pulse must match the oldest expectation
  always @(negedge clk) begin
    if (bus.if_ready_o) begin
      if (if_q.size() == 0) chk("if_unexpected_ready", 32'd1, 32'd0);
      else chk("if_rdata", bus.if_rdata_o, if_q.pop_front());
    end
    if (bus.dm_ready_o) begin
      if (dm_q.size() == 0) chk("dm_unexpected_ready", 32'd1, 32'd0);
      else chk("dm_rdata", bus.dm_rdata_o, dm_q.pop_front());
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_en"},   32'(bus.mem_en_o), 32'd0);
    chk({tag, "_mem_we"},   32'(bus.mem_we_o), 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr_o, 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata_o, 32'd0);
    chk({tag, "_grant"},    32'(bus.grant_o), 32'd0);
    chk({tag, "_if_ready"}, 32'(bus.if_ready_o), 32'd0);
    chk({tag, "_dm_ready"}, 32'(bus.dm_ready_o), 32'd0);
    chk({tag, "_if_rdata"}, bus.if_rdata_o, 32'd0);
    chk({tag, "_dm_rdata"}, bus.dm_rdata_o, 32'd0);
  endtask

  typedef struct {
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[7];

  task automatic xact(input vec_t v, output int lat, output int en_n,
                      output int we_n, output int we_cyc,
                      output logic [31:0] we_a, output logic [31:0] we_d,
                      output logic [7:0] stall_m, output logic gnt);
    lat = -1; en_n = 0; we_n = 0; we_cyc = -1;
    we_a = '0; we_d = '0; stall_m = '0; gnt = 1'bx;
    if (v.dm) dm_q.push_back(v.rdata);
    else if_q.push_back(v.rdata);
    @(posedge clk); #1;
    if (v.dm) begin
      bus.dm_req_i = 1'b1; bus.dm_we_i = v.we;
      bus.dm_addr_i = v.addr; bus.dm_wdata_i = v.wdata;
    end else begin
      bus.if_req_i = 1'b1; bus.if_addr_i = v.addr;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c < 8) stall_m[c] = bus.stall_o;
      if (bus.mem_en_o) en_n++;
      if (bus.mem_we_o) begin
        we_n++; we_cyc = c; we_a = bus.mem_addr_o; we_d = bus.mem_wdata_o;
      end
      if (v.dm ? bus.dm_ready_o : bus.if_ready_o) begin
        lat = c; gnt = bus.grant_o;
        break;
      end
    end
    bus.dm_req_i = 1'b0; bus.if_req_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, en_n, we_n, we_cyc, kd, ki, n, bad, rc;
    logic [31:0] we_a, we_d, rd;
    logic [7:0] stall_m, en_m;
    logic gnt;
    bit got[6];
    bit exp_order[6];

    vt[0] = '{0, 0, 32'h40, 32'h0, 32'h0050_0093};
    vt[1] = '{1, 1, 32'h10, 32'hDEAD_BEEF, 32'h0};
    vt[2] = '{1, 0, 32'h10, 32'h0, 32'hDEAD_BEEF};
    vt[3] = '{1, 0, 32'h24, 32'h0, pat(32'h24)};
    vt[4] = '{0, 0, 32'h48, 32'h0, pat(32'h48)};
    vt[5] = '{1, 1, 32'h80, 32'h1234_5678, pat(32'h24)};
    vt[6] = '{0, 0, 32'h80, 32'h0, 32'h1234_5678};
    exp_order = '{1, 1, 0, 1, 1, 0};

    reset = 1'b0; reset0 = 1'b0;
    bus.if_req_i = 0; bus.if_addr_i = 0; bus.flush_i = 0;
    bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_addr_i = 0;
    bus.dm_wdata_i = 0;
    bus0.if_req_i = 0; bus0.if_addr_i = 0; bus0.flush_i = 0;
    bus0.dm_req_i = 0; bus0.dm_we_i = 0; bus0.dm_addr_i = 0;
    bus0.dm_wdata_i = 0;
    #12;
    chk_zero("rst");
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk); reset = 1'b1; reset0 = 1'b1;

    for (int i = 0; i < 7; i++) begin
      xact(vt[i], lat, en_n, we_n, we_cyc, we_a, we_d, stall_m, gnt);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_en_cycles", i), 32'(en_n), 32'd2);
      chk($sformatf("v%0d_stall", i), 32'(stall_m), 32'h07);
      chk($sformatf("v%0d_grant", i), 32'(gnt), 32'(vt[i].dm));
      chk($sformatf("v%0d_we_count", i), 32'(we_n), 32'(vt[i].we));
      if (vt[i].we) begin
        chk($sformatf("v%0d_we_cycle", i), 32'(we_cyc), 32'd2);
        chk($sformatf("v%0d_we_addr", i), we_a, vt[i].addr);
        chk($sformatf("v%0d_we_data", i), we_d, vt[i].wdata);
      end
    end

    // contention: both ports keep requesting
    kd = 0; ki = 0; n = 0;
    dm_q.push_back(pat(32'h24));
    if_q.push_back(32'h0050_0093);
    @(posedge clk); #1;
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h24;
    bus.if_req_i = 1; bus.if_addr_i = 32'h40;
    for (int c = 0; c < 80 && n < 6; c++) begin
      @(negedge clk);
      if (bus.dm_ready_o) begin
        chk("cont_grant_dm", 32'(bus.grant_o), 32'd1);
        got[n] = 1; n++; kd++;
        if (kd < 4) begin
          bus.dm_addr_i = 32'h24 + 32'(4 * kd);
          dm_q.push_back(pat(bus.dm_addr_i));
        end else bus.dm_req_i = 0;
      end
      if (bus.if_ready_o) begin
        chk("cont_grant_if", 32'(bus.grant_o), 32'd0);
        got[n] = 0; n++; ki++;
        if (ki < 2) begin
          bus.if_addr_i = 32'h44;
          if_q.push_back(pat(32'h44));
        end else bus.if_req_i = 0;
      end
    end
    bus.dm_req_i = 0; bus.if_req_i = 0;
    chk("cont_count", 32'(n), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("cont_order%0d", i), 32'(got[i]), 32'(exp_order[i]));

    // flush during ACCESS, then a fetch raised in RESP
    en_m = '0; bad = 0; rc = -1;
    if_q.push_back(pat(32'h48));
    @(posedge clk); #1;
    bus.if_req_i = 1; bus.if_addr_i = 32'h44;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c < 8) en_m[c] = bus.mem_en_o;
      if (c >= 1 && c <= 6 && bus.if_rdata_o !== pat(32'h44)) bad++;
      if (c == 1) begin bus.flush_i = 1; bus.if_req_i = 0; end
      if (c == 2) bus.flush_i = 0;
      if (c == 3) begin bus.if_req_i = 1; bus.if_addr_i = 32'h48; end
      if (c > 3 && bus.if_ready_o) begin
        rc = c; bus.if_req_i = 0;
        break;
      end
    end
    bus.if_req_i = 0;
    chk("flush_en_pattern", 32'(en_m), 32'h66);
    chk("flush_rdata_held", 32'(bad), 32'd0);
    chk("flush_next_ready", 32'(rc), 32'd7);

    // reset in the first ACCESS cycle of a store
    we_n = 0;
    @(posedge clk); #1;
    bus.dm_req_i = 1; bus.dm_we_i = 1;
    bus.dm_addr_i = 32'h14; bus.dm_wdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    @(negedge clk);
    chk("rststore_in_access", 32'(bus.mem_en_o), 32'd1);
    #1 reset = 1'b0;
    #1 chk_zero("midrst");
    bus.dm_req_i = 0; bus.dm_we_i = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.mem_we_o) we_n++;
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.mem_we_o) we_n++;
    end
    chk("rststore_no_we", 32'(we_n), 32'd0);
    chk("rststore_mem_intact", mem[5], pat(32'h14));
    xact('{1, 0, 32'h20, 32'h0, pat(32'h20)},
         lat, en_n, we_n, we_cyc, we_a, we_d, stall_m, gnt);
    chk("postrst_latency", 32'(lat), 32'd3);
    chk("postrst_grant", 32'(gnt), 32'd1);

    // WAIT_STATES=0: requester drops dm_req right after grant
    en_m = '0; rc = -1; rd = '0;
    @(posedge clk); #1;
    bus0.dm_req_i = 1; bus0.dm_we_i = 0; bus0.dm_addr_i = 32'h30;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      en_m[c] = bus0.mem_en_o;
      if (c == 1) bus0.dm_req_i = 0;
      if (bus0.dm_ready_o) begin rc = c; rd = bus0.dm_rdata_o; end
    end
    chk("ws0_ready_cycle", 32'(rc), 32'd2);
    chk("ws0_rdata", rd, pat(32'h30));
    chk("ws0_en_pattern", 32'(en_m), 32'h02);
    chk("ws0_rdata_hold", bus0.dm_rdata_o, pat(32'h30));

    repeat (2) @(negedge clk);
    chk("sb_if_empty", 32'(if_q.size()), 32'd0);
    chk("sb_dm_empty", 32'(dm_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported instruction/data memory between the fetch stage (IF port) and the memory stage (DM port) of the pipelined RISC-V core. Each granted access is sequenced through a fixed number of wait states, with data requests normally taking priority and a starvation guard for fetch. The block raises a pipeline stall while any request is outstanding. It sits between `PC_Register`/IF-ID and EX-MEM on one side and the unified memory on the other.

## Interface

- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width.
- `WAIT_STATES`, default 1: extra memory cycles per access. Legal range is 0..7.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `if_req_i` in 1: fetch request. Held until `if_ready_o` is returned.
- `if_addr_i` in ADDR_WIDTH: fetch address.
- `flush_i` in 1: discard the in-flight or pending fetch.
- `if_rdata_o` out DATA_WIDTH: fetched instruction.
- `if_ready_o` out 1: fetch complete. One-cycle pulse.
- `dm_req_i` in 1: data request. Held until `dm_ready_o` is returned.
- `dm_we_i` in 1: 1 = store, 0 = load.
- `dm_addr_i` in ADDR_WIDTH: data address.
- `dm_wdata_i` in DATA_WIDTH: store data.
- `dm_rdata_o` out DATA_WIDTH: load data.
- `dm_ready_o` out 1: data access complete. One-cycle pulse.
- `mem_en_o` out 1: memory access active.
- `mem_we_o` out 1: memory write strobe.
- `mem_addr_o` out ADDR_WIDTH: memory address.
- `mem_wdata_o` out DATA_WIDTH: memory write data.
- `mem_rdata_i` in DATA_WIDTH: memory read data. Combinational read, valid in the same cycle as the address.
- `grant_o` out 1: owner of the current or last grant. 0 = IF, 1 = DM.
- `stall_o` out 1: pipeline stall.

## Operation

- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - If `dm_req_i`=1 and the starvation counter is below 2, grant DM.
  - Otherwise, if `if_req_i`=1 and `flush_i`=0, grant IF.
  - Otherwise, if `dm_req_i`=1, grant DM.
  - On any grant: latch the owner, address, `we` (forced 0 for IF) and write data; load the wait counter with WAIT_STATES; go to ACCESS.
- **ACCESS:**
  - `mem_en_o`=1, driven from the latched address and data.
  - The counter decrements each cycle.
  - On the cycle where the counter is 0:
    - assert `mem_we_o` = latched `we` (exactly one write strobe per store);
    - capture `mem_rdata_i` into the owner's rdata register (loads and fetches only);
    - go to RESP.
- **RESP:**
  - Pulse the owner's ready output.
  - Exception: if the owner is IF and `flush_i` was seen at any point since the grant (including this cycle), suppress `if_ready_o` and leave `if_rdata_o` unchanged.
  - Always return to IDLE. There is no back-to-back grant from RESP.
- **Starvation counter (2 bits, saturating):**
  - Increments on each DM grant made while `if_req_i`=1.
  - Clears on any IF grant, or when IF is not requesting.
  - Effect: a waiting fetch is granted after at most 2 consecutive DM accesses.
- **Latched requests:** request inputs are sampled only in IDLE. Changes after grant are ignored and the transaction always completes.
- **rdata registers:** `if_rdata_o` and `dm_rdata_o` hold their value between completions. A store does not modify `dm_rdata_o`.
- **stall_o** is combinational: (`if_req_i` & ~`if_ready_o` & ~`flush_i`) | (`dm_req_i` & ~`dm_ready_o`).

## Timing

- **Reset:** while `reset`=0, asynchronously force:
  - FSM = IDLE, counters = 0, `grant_o`=0;
  - all `mem_*` outputs = 0, both ready outputs = 0, both rdata outputs = 0.
- **Reset mid-ACCESS:** the transaction is abandoned and no `mem_we_o` pulse is issued.
- **Latency** from a request sampled in IDLE (cycle 0) to ready: WAIT_STATES+2 cycles.
  - ACCESS occupies cycles 1..WAIT_STATES+1.
  - RESP is cycle WAIT_STATES+2.
  - With WAIT_STATES=0: ACCESS is one cycle and ready arrives at cycle 2.
- **Throughput:** one access per WAIT_STATES+3 cycles (IDLE → ACCESS → RESP → IDLE).
- **Simultaneous requests in IDLE:** DM wins unless the starvation counter is 2.
- **`flush_i` with an IF request in IDLE:** no IF grant; a DM request may still be granted.
- `mem_en_o`, `mem_addr_o` and `mem_wdata_o` are registered-state driven with no glitch on grant. They are 0 outside ACCESS.

## Test plan

- **Single fetch** (WAIT_STATES=1): `if_req_i`=1, addr 0x40, memory returns 0x00500093.
  - `mem_en_o` is high for 2 cycles.
  - `if_ready_o` pulses in cycle 3 with `if_rdata_o`=0x00500093.
  - `stall_o` is high in cycles 0–2.
- **Store:** `dm_req_i`=1, `we`=1, addr 0x10, wdata 0xDEADBEEF.
  - Exactly one `mem_we_o` pulse, in the final ACCESS cycle, with address 0x10 and data 0xDEADBEEF.
  - `dm_ready_o` pulses at cycle 3.
  - `dm_rdata_o` is unchanged.
- **Contention:** both ports request continuously.
  - Grant order is DM, DM, IF, DM, DM, IF.
  - `grant_o` toggles accordingly, and no fetch waits for more than 2 DM accesses.
- **Flush:** assert `flush_i` during the ACCESS of a fetch to 0x44.
  - No `if_ready_o` pulse and `if_rdata_o` keeps its prior value.
  - The FSM returns to IDLE on schedule.
- **Reset mid-store:** drive `reset`=0 in the first ACCESS cycle of a store.
  - All outputs go to 0 immediately and no `mem_we_o` occurs.
  - After release, a new load from 0x20 completes normally.
- **Requester misbehaviour** (WAIT_STATES=0): drop `dm_req_i` one cycle after grant.
  - The access still completes, with `dm_ready_o` at cycle 2.
  - The next IDLE sees no request.
